// File: rtl/exers_sched_pkg.sv
// rtl/exers_sched_pkg.sv - shared widths, entry layout and tag-match helper for exers_sched
package exers_sched_pkg;

  localparam int EXERS_DEPTH = 8;
  localparam int ROBID_W     = 8;
  localparam int RD_W        = 6;
  localparam int OP_W        = 5;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    logic               rdy1;
    logic [DATA_W-1:0]  val1;
    logic               rdy2;
    logic [DATA_W-1:0]  val2;
    logic [DATA_W-1:0]  imm;
  } entry_t;

  // A waiting operand carries its producer's ROB id in the low bits of its value field.
  function automatic logic tag_hit(input logic rdy, input logic [ROBID_W-1:0] tag,
                                   input logic wb_valid, input logic [ROBID_W-1:0] wb_robid);
    return wb_valid & ~rdy & (tag == wb_robid);
  endfunction

endpackage

// File: rtl/exers_sched_age_matrix.sv
// rtl/exers_sched_age_matrix.sv - age matrix tracking entry order; grants the oldest requester
// age_q[r][c] = 1 means entry r is older than entry c.
module exers_sched_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] older_req;

  // A new entry is younger than everything valid; freed entries drop out of both axes.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < DEPTH; c++) begin
        age_d[r][c] = age_q[r][c];
        if (flush_i || free_i[r] || free_i[c] || alloc_i[r]) begin
          age_d[r][c] = 1'b0;
        end else if (alloc_i[c]) begin
          age_d[r][c] = valid_i[r];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_req[i] = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        older_req[i] = older_req[i] | (req_i[j] & age_q[j][i]);
      end
      grant_o[i] = req_i[i] & ~older_req[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        age_q[r] <= '0;
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/exers_sched.sv
// rtl/exers_sched.sv - integer reservation station: dispatch buffer, operand wakeup, oldest-ready issue
module exers_sched
  import exers_sched_pkg::*;
#(
  parameter int DEPTH = EXERS_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rename_exers_write,
  input  logic [OP_W-1:0]     rename_op,
  input  logic [ROBID_W-1:0]  rename_robid,
  input  logic [RD_W-1:0]     rename_rd,
  input  logic                rename_op1ready,
  input  logic                rename_op2ready,
  input  logic [DATA_W-1:0]   rename_op1,
  input  logic [DATA_W-1:0]   rename_op2,
  input  logic [DATA_W-1:0]   rename_imm,
  output logic                exers_stall,
  input  logic                wb_valid,
  input  logic                wb_error,
  input  logic [ROBID_W-1:0]  wb_robid,
  input  logic [DATA_W-1:0]   wb_result,
  input  logic                rob_flush,
  output logic                issue_valid,
  output logic [OP_W-1:0]     issue_op,
  output logic [ROBID_W-1:0]  issue_robid,
  output logic [RD_W-1:0]     issue_rd,
  output logic [DATA_W-1:0]   issue_op1,
  output logic [DATA_W-1:0]   issue_op2,
  output logic [DATA_W-1:0]   issue_imm,
  input  logic                alu_stall
);

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  entry_t           new_e;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] alloc_oh, free_oh, ready_vec, grant;
  logic             wr_accept, fire, found, hit1, hit2;
  logic             unused_wb_error;

  // Faulting results still wake consumers; the fault is handled at commit.
  assign unused_wb_error = wb_error;

  assign exers_stall = &valid_q;
  assign wr_accept   = rename_exers_write & ~exers_stall & ~rob_flush;
  assign issue_valid = (|grant) & ~rob_flush;
  assign fire        = issue_valid & ~alu_stall;
  assign free_oh     = fire ? grant : '0;

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        alloc_oh[i] = wr_accept;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid_q[i] & entry_q[i].rdy1 & entry_q[i].rdy2;
    end
  end

  exers_sched_age_matrix #(.DEPTH(DEPTH)) u_age_matrix (
    .clk     (clk),
    .rst_n   (rst),
    .alloc_i (alloc_oh),
    .free_i  (free_oh),
    .flush_i (rob_flush),
    .valid_i (valid_q),
    .req_i   (ready_vec),
    .grant_o (grant)
  );

  // Incoming op snoops the same-cycle broadcast so it cannot miss its producer.
  always_comb begin
    hit1       = tag_hit(rename_op1ready, rename_op1[ROBID_W-1:0], wb_valid, wb_robid);
    hit2       = tag_hit(rename_op2ready, rename_op2[ROBID_W-1:0], wb_valid, wb_robid);
    new_e.op    = rename_op;
    new_e.robid = rename_robid;
    new_e.rd    = rename_rd;
    new_e.rdy1  = rename_op1ready | hit1;
    new_e.val1  = hit1 ? wb_result : rename_op1;
    new_e.rdy2  = rename_op2ready | hit2;
    new_e.val2  = hit2 ? wb_result : rename_op2;
    new_e.imm   = rename_imm;
  end

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (tag_hit(entry_q[i].rdy1, entry_q[i].val1[ROBID_W-1:0], wb_valid, wb_robid)) begin
          entry_d[i].rdy1 = 1'b1;
          entry_d[i].val1 = wb_result;
        end
        if (tag_hit(entry_q[i].rdy2, entry_q[i].val2[ROBID_W-1:0], wb_valid, wb_robid)) begin
          entry_d[i].rdy2 = 1'b1;
          entry_d[i].val2 = wb_result;
        end
      end
      if (alloc_oh[i]) begin
        entry_d[i] = new_e;
        valid_d[i] = 1'b1;
      end
    end
    valid_d = valid_d & ~free_oh;
    if (rob_flush) begin
      valid_d = '0;
    end
  end

  // Grant is one-hot or zero, so an OR-mux yields all-zero data when nothing is ready.
  always_comb begin
    issue_op    = '0;
    issue_robid = '0;
    issue_rd    = '0;
    issue_op1   = '0;
    issue_op2   = '0;
    issue_imm   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_op    = issue_op    | entry_q[i].op;
        issue_robid = issue_robid | entry_q[i].robid;
        issue_rd    = issue_rd    | entry_q[i].rd;
        issue_op1   = issue_op1   | entry_q[i].val1;
        issue_op2   = issue_op2   | entry_q[i].val2;
        issue_imm   = issue_imm   | entry_q[i].imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_exers_sched.sv
// tb/tb_exers_sched.sv - directed scoreboard bench for exers_sched
module tb_exers_sched;

  typedef struct packed {
    logic [4:0]  op;
    logic [7:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rename_exers_write;
  logic [4:0]  rename_op;
  logic [7:0]  rename_robid;
  logic [5:0]  rename_rd;
  logic        rename_op1ready, rename_op2ready;
  logic [31:0] rename_op1, rename_op2, rename_imm;
  logic        exers_stall;
  logic        wb_valid, wb_error;
  logic [7:0]  wb_robid;
  logic [31:0] wb_result;
  logic        rob_flush;
  logic        issue_valid;
  logic [4:0]  issue_op;
  logic [7:0]  issue_robid;
  logic [5:0]  issue_rd;
  logic [31:0] issue_op1, issue_op2, issue_imm;
  logic        alu_stall;

  int  compared   = 0;
  int  mismatched = 0;
  tx_t exp_q[$];

  exers_sched dut (
    .clk(clk), .rst(rst),
    .rename_exers_write(rename_exers_write), .rename_op(rename_op),
    .rename_robid(rename_robid), .rename_rd(rename_rd),
    .rename_op1ready(rename_op1ready), .rename_op2ready(rename_op2ready),
    .rename_op1(rename_op1), .rename_op2(rename_op2), .rename_imm(rename_imm),
    .exers_stall(exers_stall),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid), .wb_result(wb_result),
    .rob_flush(rob_flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_robid(issue_robid),
    .issue_rd(issue_rd), .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_imm(issue_imm), .alu_stall(alu_stall)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && issue_valid && !alu_stall) begin
      tx_t act, e;
      act = '{issue_op, issue_robid, issue_rd, issue_op1, issue_op2, issue_imm};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_issue: got robid=%h op1=%h, required no issue", issue_robid, issue_op1);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          mismatched++;
          $display("FAIL issue_robid_%h: got %h, required %h", e.robid, act, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic [4:0] op, input logic [7:0] robid, input logic [5:0] rd,
                           input logic r1, input logic [31:0] v1,
                           input logic r2, input logic [31:0] v2, input logic [31:0] imm);
    rename_exers_write = 1'b1;
    rename_op = op; rename_robid = robid; rename_rd = rd;
    rename_op1ready = r1; rename_op1 = v1;
    rename_op2ready = r2; rename_op2 = v2;
    rename_imm = imm;
  endtask

  task automatic write(input logic [4:0] op, input logic [7:0] robid, input logic [5:0] rd,
                       input logic r1, input logic [31:0] v1,
                       input logic r2, input logic [31:0] v2, input logic [31:0] imm);
    set_write(op, robid, rd, r1, v1, r2, v2, imm);
    tick();
    rename_exers_write = 1'b0;
  endtask

  task automatic wake(input logic [7:0] tag, input logic [31:0] res);
    wb_valid = 1'b1; wb_robid = tag; wb_result = res;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic [4:0] op, input logic [7:0] robid, input logic [5:0] rd,
                           input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm);
    exp_q.push_back('{op, robid, rd, op1, op2, imm});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rename_exers_write = 1'b0; rename_op = '0; rename_robid = '0; rename_rd = '0;
    rename_op1ready = 1'b0; rename_op2ready = 1'b0; rename_op1 = '0; rename_op2 = '0;
    rename_imm = '0; wb_valid = 1'b0; wb_error = 1'b0; wb_robid = '0; wb_result = '0;
    rob_flush = 1'b0; alu_stall = 1'b0;
    tick(); tick();
    check("reset_stall", 32'(exers_stall), 32'd0);
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    check("reset_issue_op1", issue_op1, 32'd0);
    rst = 1'b1;
    tick();

    // Ready on arrival
    expect_tx(5'd3, 8'h10, 6'd1, 32'd5, 32'd7, 32'h100);
    write(5'd3, 8'h10, 6'd1, 1'b1, 32'd5, 1'b1, 32'd7, 32'h100);
    check("arrival_present", 32'(issue_valid), 32'd1);
    tick();
    check("arrival_freed", 32'(issue_valid), 32'd0);

    // Wakeup (wb_error set to show it does not block wakeup)
    write(5'd4, 8'h11, 6'd2, 1'b0, 32'h20, 1'b1, 32'd3, 32'd0);
    tick();
    check("wakeup_waiting", 32'(issue_valid), 32'd0);
    expect_tx(5'd4, 8'h11, 6'd2, 32'hDEADBEEF, 32'd3, 32'd0);
    wb_error = 1'b1;
    wake(8'h20, 32'hDEADBEEF);
    wb_error = 1'b0;
    check("wakeup_present", 32'(issue_valid), 32'd1);
    tick();

    // Same-cycle bypass
    expect_tx(5'd5, 8'h12, 6'd3, 32'd11, 32'd9, 32'd0);
    wb_valid = 1'b1; wb_robid = 8'h30; wb_result = 32'd9;
    write(5'd5, 8'h12, 6'd3, 1'b1, 32'd11, 1'b0, 32'h30, 32'd0);
    wb_valid = 1'b0;
    check("bypass_present", 32'(issue_valid), 32'd1);
    tick();

    // Oldest first: A waits, B and C issue in order
    expect_tx(5'd1, 8'h22, 6'd7, 32'd1, 32'd2, 32'd0);
    expect_tx(5'd2, 8'h23, 6'd8, 32'd3, 32'd4, 32'd0);
    write(5'd6, 8'h21, 6'd4, 1'b0, 32'h40, 1'b1, 32'h66, 32'h1234);
    write(5'd1, 8'h22, 6'd7, 1'b1, 32'd1, 1'b1, 32'd2, 32'd0);
    write(5'd2, 8'h23, 6'd8, 1'b1, 32'd3, 1'b1, 32'd4, 32'd0);
    tick();
    check("oldest_only_a_left", 32'(issue_valid), 32'd0);

    // Woken A overtakes a stalled younger B2
    alu_stall = 1'b1;
    expect_tx(5'd6, 8'h21, 6'd4, 32'h55, 32'h66, 32'h1234);
    expect_tx(5'd9, 8'h24, 6'd9, 32'd10, 32'd20, 32'd0);
    write(5'd9, 8'h24, 6'd9, 1'b1, 32'd10, 1'b1, 32'd20, 32'd0);
    tick();
    check("stall_holds_b2", 32'(issue_robid), 32'h24);
    wake(8'h40, 32'h55);
    check("stall_switch_to_a", 32'(issue_robid), 32'h21);
    alu_stall = 1'b0;
    tick(); tick();

    // Full
    for (int i = 0; i < 8; i++) begin
      write(5'd8, 8'(8'h50 + i), 6'd5, 1'b0, 32'(8'h60 + i), 1'b1, 32'(i), 32'd0);
    end
    check("full_stall", 32'(exers_stall), 32'd1);
    write(5'd10, 8'h70, 6'd6, 1'b1, 32'd1, 1'b1, 32'd1, 32'd0);
    check("full_drop_no_issue", 32'(issue_valid), 32'd0);
    check("full_still_stall", 32'(exers_stall), 32'd1);
    expect_tx(5'd8, 8'h53, 6'd5, 32'h77, 32'd3, 32'd0);
    wake(8'h63, 32'h77);
    check("full_issue_still_stall", 32'(exers_stall), 32'd1);
    tick();
    check("full_stall_released", 32'(exers_stall), 32'd0);

    // Flush clears the seven remaining entries
    rob_flush = 1'b1;
    tick();
    rob_flush = 1'b0;
    check("flush_empty_stall", 32'(exers_stall), 32'd0);

    // Flush with five entries (one presented) and a pending write
    alu_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write(5'd11, 8'(8'h80 + i), 6'd1, 1'b0, 32'(8'hA0 + i), 1'b1, 32'd0, 32'd0);
    end
    write(5'd12, 8'h84, 6'd2, 1'b1, 32'd1, 1'b1, 32'd2, 32'd0);
    check("preflush_present", 32'(issue_robid), 32'h84);
    set_write(5'd13, 8'h89, 6'd3, 1'b1, 32'd5, 1'b1, 32'd6, 32'd0);
    rob_flush = 1'b1;
    #1;
    check("flush_masks_issue", 32'(issue_valid), 32'd0);
    tick();
    rob_flush = 1'b0; rename_exers_write = 1'b0; alu_stall = 1'b0;
    check("postflush_no_issue", 32'(issue_valid), 32'd0);
    wake(8'hA0, 32'h1);
    tick();
    check("postflush_wake_nothing", 32'(issue_valid), 32'd0);

    // Asynchronous reset mid-issue
    alu_stall = 1'b1;
    write(5'd7, 8'h90, 6'd3, 1'b1, 32'hAA, 1'b1, 32'hBB, 32'hCC);
    check("prereset_present", 32'(issue_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("reset_async_valid", 32'(issue_valid), 32'd0);
    check("reset_async_op1", issue_op1, 32'd0);
    check("reset_async_robid", 32'(issue_robid), 32'd0);
    check("reset_async_imm", issue_imm, 32'd0);
    tick();
    rst = 1'b1; alu_stall = 1'b0;
    tick(); tick();
    check("postreset_no_issue", 32'(issue_valid), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
